// File: rtl/onchip_mem_stream_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_master_pkg
// Description : Shared types and default parameter constants for the on-chip
//               memory stream master (job FSM state type, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package onchip_mem_stream_master_pkg;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_stream_master_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_resp_fifo
// Description : Synchronous show-ahead FIFO buffering read responses. The head
//               word is always visible on data_o while empty_o is low.
// Ports       : clk, reset (async, active-high)
//               push_i/data_i  - write side (ignored when full unless popping)
//               pop_i          - read side (ignored when empty)
//               data_o/empty_o - head word and empty flag
//               count_o        - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_resp_fifo
    import onchip_mem_stream_master_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic do_push;
    logic do_pop;

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/onchip_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_master
// Description : Moves a block of words between an on-chip memory (Avalon-MM
//               style master) and streaming ports. Read jobs stream memory out
//               on src_*, write jobs take words from snk_* into memory.
// Ports       : clk, reset (async, active-high)
//               cmd_*       - job command handshake (write flag, addr, len)
//               avm_*       - memory master port (waitrequest, pipelined reads)
//               src_*       - read-job output stream
//               snk_*       - write-job input stream
//               busy, done  - job in progress / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_master
    import onchip_mem_stream_master_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    // command
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    // memory master
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    // read-job source stream
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    // write-job sink stream
    input  logic [DATA_W-1:0]   snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    // status
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W:0]     rem_q,   rem_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic                wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                fifo_push;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_used;
    logic                rd_credit;
    logic                rd_acc;
    logic                wr_acc;

    // ------------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------------
    onchip_mem_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (avm_readdata),
        .pop_i   (src_ready),
        .data_o  (src_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Responses are only accepted against an outstanding read, so data from a
    // job abandoned by reset is dropped once the counter has been cleared.
    assign fifo_push = avm_readdatavalid && (outst_q != '0);

    // Every issued read reserves a FIFO slot until it is popped; this sum can
    // only fall while a read is stalled, so avm_read stays high under wait.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
    assign rd_credit   = credit_used < (CW+1)'(FIFO_DEPTH);

    assign rd_acc = avm_read && !avm_waitrequest;
    assign wr_acc = wr_pend_q && !avm_waitrequest;

    assign cmd_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign avm_address    = addr_q;
    assign avm_write      = wr_pend_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
    assign src_valid      = !fifo_empty;

    // ------------------------------------------------------------------------
    // Job FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_pend_d = wr_pend_q;
        wdata_d   = wdata_q;
        outst_d   = outst_q + CW'(rd_acc) - CW'(fifo_push);
        avm_read  = 1'b0;
        snk_ready = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    // Zero-length jobs skip the bus and complete via DRAIN.
                    if (cmd_len == '0) begin
                        state_d = ST_DRAIN;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                avm_read = (rem_q != '0) && rd_credit;
                if (rd_acc) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_WRITE: begin
                if (wr_acc) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    wr_pend_d = 1'b0;
                end
                // rem_q counts words not yet captured from the sink.
                snk_ready = (rem_q != '0) && (!wr_pend_q || wr_acc);
                if (snk_ready && snk_valid) begin
                    wdata_d   = snk_data;
                    wr_pend_d = 1'b1;
                    rem_d     = rem_q - (ADDR_W+1)'(1);
                end
                if (wr_acc && (rem_q == '0)) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                done = fifo_empty && (outst_q == '0);
                if (done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            wr_pend_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            wr_pend_q <= wr_pend_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_stream_master
// Description : Scoreboard bench for onchip_mem_stream_master. A memory slave
//               model with configurable latency and waitrequest serves the
//               master; expected read words are queued at job issue and popped
//               by a monitor whenever the source stream transfers a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_master;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [AW:0]     cmd_len = '0;
    logic [AW-1:0]   avm_address;
    logic            avm_read;
    logic            avm_write;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [DW-1:0]   avm_readdata = '0;
    logic            avm_waitrequest = 1'b0;
    logic            avm_readdatavalid = 1'b0;
    logic [DW-1:0]   src_data;
    logic            src_valid;
    logic            src_ready = 1'b0;
    logic [DW-1:0]   snk_data = '0;
    logic            snk_valid = 1'b0;
    logic            snk_ready;
    logic            busy;
    logic            done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // memory slave model state
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          dl_v [4];
    logic [DW-1:0] dl_d [4];
    int            lat = 1;
    bit            rand_wait = 1'b0;
    bit            chk_stable = 1'b0;
    logic          acc_pending = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // scoreboard / monitor state
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] snk_q [$];
    int pops = 0;
    int last_pop_cyc = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    bit acc_seen = 1'b0;
    int inflight = 0;
    int max_inflight = 0;
    int bus_ops = 0;

    onchip_mem_stream_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .snk_data          (snk_data),
        .snk_valid         (snk_valid),
        .snk_ready         (snk_ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave drive side: response delay line, waitrequest, sink stream.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            dl_v[i] = dl_v[i+1];
            dl_d[i] = dl_d[i+1];
        end
        dl_v[3] = 1'b0;
        if (acc_pending) begin
            dl_v[lat-1] = 1'b1;
            dl_d[lat-1] = mem[acc_addr];
        end
        avm_readdatavalid = dl_v[0];
        avm_readdata      = dl_d[0];
        avm_waitrequest   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        snk_valid         = (snk_q.size() > 0);
        snk_data          = (snk_q.size() > 0) ? snk_q[0] : '0;
    end

    // Sampling side: bus acceptance, scoreboard pops, protocol checks.
    always @(negedge clk) begin
        acc_pending = 1'b0;
        if (!reset) begin
            if (avm_read && avm_write) begin
                tests++; fails++;
                $display("FAIL rd_wr_excl: read=%b write=%b both high", avm_read, avm_write);
            end
            if (done && cmd_ready) begin
                tests++; fails++;
                $display("FAIL done_ready_excl: done=%b cmd_ready=%b both high", done, cmd_ready);
            end
            if (chk_stable && prev_hold) begin
                check("hold_addr", DW'(avm_address), DW'(prev_addr));
                check("hold_read", DW'(avm_read), 32'd1);
            end
            prev_hold = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            if (avm_read || avm_write) bus_ops++;
            if (cmd_valid && cmd_ready) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc;
            end
            if (avm_read && !avm_waitrequest) begin
                acc_pending = 1'b1;
                acc_addr    = avm_address;
                inflight++;
                if (inflight > max_inflight) max_inflight = inflight;
            end
            if (avm_write && !avm_waitrequest) begin
                mem[avm_address] = avm_writedata;
                last_wr_cyc = cyc;
                check("byteenable", DW'(avm_byteenable), 32'hF);
            end
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_word: got %h expected none (queue empty)", src_data);
                end else begin
                    check("rd_word", src_data, exp_q.pop_front());
                end
                pops++;
                last_pop_cyc = cyc;
                inflight--;
            end
            if (snk_valid && snk_ready) void'(snk_q.pop_front());
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [AW:0] len);
        int k;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        done_cnt = 0; acc_seen = 1'b0;
        k = 0;
        while (!acc_seen && k < 100) begin tick(); k++; end
        check("cmd_accept", DW'(acc_seen), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin tick(); k++; end
        if (done_cnt == 0) begin
            tests++; fails++;
            $display("FAIL %s_timeout: done never seen, waited %0d cycles", nm, k);
        end
        repeat (3) tick();
        check({nm, "_done_once"}, DW'(done_cnt), 32'd1);
    endtask

    task automatic push_read(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pattern(a + AW'(i)));
    endtask

    initial begin : main
        for (int i = 0; i < (1 << AW); i++) mem[i] = pattern(AW'(i));
        for (int i = 0; i < 4; i++) begin dl_v[i] = 1'b0; dl_d[i] = '0; end

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("rst_cmd_ready", DW'(cmd_ready), 32'd1);
        check("rst_avm_read", DW'(avm_read), 32'd0);
        check("rst_avm_write", DW'(avm_write), 32'd0);
        check("rst_avm_address", DW'(avm_address), 32'd0);
        check("rst_writedata", avm_writedata, 32'd0);
        check("rst_src_valid", DW'(src_valid), 32'd0);
        check("rst_snk_ready", DW'(snk_ready), 32'd0);
        check("rst_busy", DW'(busy), 32'd0);
        check("rst_done", DW'(done), 32'd0);

        // ---------------- read 0x0010 len 4, latency 1 ----------------
        lat = 1; src_ready = 1'b1;
        push_read(14'h0010, 4);
        issue(1'b0, 14'h0010, 15'd4);
        check("rd4_busy", DW'(busy), 32'd1);
        wait_done("rd4");
        check("rd4_done_lat", DW'(done_cyc), DW'(last_pop_cyc + 1));
        check("rd4_sb_empty", DW'(exp_q.size()), 32'd0);

        // ---------------- write 0x3FFE len 4 with address wrap ----------------
        snk_q.push_back(32'hAAAA_0001);
        snk_q.push_back(32'hBBBB_0002);
        snk_q.push_back(32'hCCCC_0003);
        snk_q.push_back(32'hDDDD_0004);
        issue(1'b1, 14'h3FFE, 15'd4);
        wait_done("wr4");
        check("wr4_done_lat", DW'(done_cyc), DW'(last_wr_cyc + 1));
        check("wr_mem_3FFE", mem[14'h3FFE], 32'hAAAA_0001);
        check("wr_mem_3FFF", mem[14'h3FFF], 32'hBBBB_0002);
        check("wr_mem_0000", mem[14'h0000], 32'hCCCC_0003);
        check("wr_mem_0001", mem[14'h0001], 32'hDDDD_0004);

        // ---------------- read len 16 with sink backpressure ----------------
        src_ready = 1'b0; max_inflight = 0;
        push_read(14'h0100, 16);
        issue(1'b0, 14'h0100, 15'd16);
        repeat (20) tick();
        check("bp_src_valid", DW'(src_valid), 32'd1);
        @(posedge clk); #1 src_ready = 1'b1;
        wait_done("rd16");
        check("rd16_max_inflight_le4", DW'(max_inflight <= FD), 32'd1);
        check("rd16_sb_empty", DW'(exp_q.size()), 32'd0);

        // ---------------- random waitrequest, latency 3, len 8 ----------------
        lat = 3; rand_wait = 1'b1; chk_stable = 1'b1;
        push_read(14'h0200, 8);
        issue(1'b0, 14'h0200, 15'd8);
        wait_done("rd8w");
        check("rd8w_sb_empty", DW'(exp_q.size()), 32'd0);
        rand_wait = 1'b0; chk_stable = 1'b0;
        @(posedge clk); #1;

        // ---------------- zero-length job ----------------
        tick();
        bus_ops = 0;
        issue(1'b0, 14'h0040, 15'd0);
        wait_done("len0");
        check("len0_no_bus", DW'(bus_ops), 32'd0);
        check("len0_done_lat", DW'(done_cyc), DW'(acc_cyc + 1));

        // ---------------- reset in the middle of a read job ----------------
        begin
            int base;
            int k;
            lat = 3;
            base = pops;
            push_read(14'h0300, 8);
            issue(1'b0, 14'h0300, 15'd8);
            k = 0;
            while ((pops - base) < 3 && k < 200) begin tick(); k++; end
            check("mid_three_pops", DW'(pops - base), 32'd3);
            #2 reset = 1'b1;
            #1;
            check("mid_rst_avm_read", DW'(avm_read), 32'd0);
            check("mid_rst_avm_write", DW'(avm_write), 32'd0);
            check("mid_rst_avm_address", DW'(avm_address), 32'd0);
            check("mid_rst_writedata", avm_writedata, 32'd0);
            check("mid_rst_src_valid", DW'(src_valid), 32'd0);
            check("mid_rst_busy", DW'(busy), 32'd0);
            check("mid_rst_done", DW'(done), 32'd0);
            check("mid_rst_snk_ready", DW'(snk_ready), 32'd0);
            exp_q.delete();
            inflight = 0;
            @(posedge clk); #1 reset = 1'b0;
            tick();
            check("post_rst_cmd_ready", DW'(cmd_ready), 32'd1);
            repeat (5) tick();
            check("post_rst_stale_dropped", DW'(src_valid), 32'd0);
        end

        // ---------------- next job after reset ----------------
        lat = 1;
        push_read(14'h0020, 4);
        issue(1'b0, 14'h0020, 15'd4);
        wait_done("rd_after_rst");
        check("rd_after_rst_lat", DW'(done_cyc), DW'(last_pop_cyc + 1));
        check("rd_after_rst_sb_empty", DW'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
